alien_bomb_dropper: RTL and testbench

//  Consumes the formation's armed matrix (lowest living alien per column) and formation origin.

---
 rtl/alien_bomb_dropper.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_alien_bomb_dropper.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_bomb_dropper.sv
// rtl/alien_bomb_dropper.sv - single-bomb spawner and dropper for the alien formation
//
// Purpose:
//   Picks one armed alien (lowest living alien of a column), spawns a bomb just
//   below it, drops the bomb BOMB_SPEED px per step_tick, tests it against the
//   player hitbox and retires it at the bottom of the screen. Also produces a
//   registered bomb_pixel for the VGA mixer. All coordinates are 16-bit screen
//   space, shared with the formation.
//
// Configuration macro:
//   ALIEN_BOMB_RANDOM_EN - defined: the column search starts at lfsr % NUM_COLUMNS.
//                          undefined: it starts at a round-robin pointer that
//                          advances after every spawn (no LFSR is built).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   game_active           0 parks the block in IDLE and removes the bomb
//   step_tick             1-cycle movement strobe (cooldown and fall timing)
//   armed_matrix[r][c]    1 = alien at row r, column c may fire
//   formation_x/_y        screen position of alien[0][0]
//   player_x/_y           player hitbox top-left corner
//   scan_x/_y             current VGA scan position
//   bomb_active           bomb in flight
//   bomb_x/_y             bomb top-left corner
//   bomb_pixel            registered: bomb covers the scan point
//   player_hit            1-cycle pulse when the bomb hits the player

module alien_bomb_dropper #(
   parameter int          NUM_ROWS        = 2,
   parameter int          NUM_COLUMNS     = 4,
   parameter int          ALIEN_SPACING_X = 64,
   parameter int          ALIEN_SPACING_Y = 32,
   parameter int          ALIEN_WIDTH     = 32,
   parameter int          ALIEN_HEIGHT    = 16,
   parameter int          BOMB_WIDTH      = 2,
   parameter int          BOMB_HEIGHT     = 8,
   parameter int          BOMB_SPEED      = 4,
   parameter int          SCREEN_HEIGHT   = 480,
   parameter int          PLAYER_WIDTH    = 32,
   parameter int          PLAYER_HEIGHT   = 16,
   parameter int          COOLDOWN_STEPS  = 16,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  game_active,
   input  logic                                  step_tick,
   input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  armed_matrix,
   input  logic [15:0]                           formation_x,
   input  logic [15:0]                           formation_y,
   input  logic [15:0]                           player_x,
   input  logic [15:0]                           player_y,
   input  logic [15:0]                           scan_x,
   input  logic [15:0]                           scan_y,
   output logic                                  bomb_active,
   output logic [15:0]                           bomb_x,
   output logic [15:0]                           bomb_y,
   output logic                                  bomb_pixel,
   output logic                                  player_hit
);

   localparam int CW  = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
   localparam int PCW = $clog2(NUM_COLUMNS + 1);
   localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   localparam logic [15:0] COOLDOWN_RELOAD = 16'(COOLDOWN_STEPS);
   // Bomb is horizontally centred under the alien sprite.
   localparam logic [15:0] SPAWN_X_OFF     = 16'(ALIEN_WIDTH / 2 - BOMB_WIDTH / 2);
   localparam logic [15:0] SPAWN_Y_OFF     = 16'(ALIEN_HEIGHT);
   localparam logic [15:0] SPACING_X       = 16'(ALIEN_SPACING_X);
   localparam logic [15:0] SPACING_Y       = 16'(ALIEN_SPACING_Y);
   localparam logic [15:0] BOMB_W          = 16'(BOMB_WIDTH);
   localparam logic [15:0] BOMB_H          = 16'(BOMB_HEIGHT);
   localparam logic [15:0] FALL_STEP       = 16'(BOMB_SPEED);
   localparam logic [15:0] SCREEN_H        = 16'(SCREEN_HEIGHT);
   localparam logic [15:0] PLAYER_W        = 16'(PLAYER_WIDTH);
   localparam logic [15:0] PLAYER_H        = 16'(PLAYER_HEIGHT);
   localparam logic [CW-1:0]  LAST_COL     = CW'(NUM_COLUMNS - 1);
   localparam logic [PCW-1:0] LAST_PROBE   = PCW'(NUM_COLUMNS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_FALL   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     cooldown_q, cooldown_d;
   logic [CW-1:0]   col_ptr_q, col_ptr_d;
   logic [PCW-1:0]  probe_cnt_q, probe_cnt_d;
   logic            bomb_active_q, bomb_active_d;
   logic [15:0]     bomb_x_q, bomb_x_d;
   logic [15:0]     bomb_y_q, bomb_y_d;
   logic            bomb_pixel_q, bomb_pixel_d;
   logic            player_hit_q, player_hit_d;

   logic [CW-1:0]   start_col;
   logic            spawn;
   logic            probe_hit;
   logic [RW-1:0]   probe_row;
   logic [15:0]     spawn_x;
   logic [15:0]     spawn_y;
   logic [15:0]     fall_y;
   logic            fall_hit;
   logic            fall_bottom;

   // ------------------------------------------------------------------
   // Start column source
   // ------------------------------------------------------------------
`ifdef ALIEN_BOMB_RANDOM_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        unused_spawn;

   // Galois form, taps 16,14,13,11 (right shift, feedback mask 0xB400).
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign start_col    = CW'(lfsr_q % 16'(NUM_COLUMNS));
   assign unused_spawn = spawn;
`else
   logic [CW-1:0] rr_q, rr_d;
   logic          unused_seed;

   // Round-robin start column moves on only after a bomb actually spawns,
   // so an empty search does not skip columns.
   always_comb begin
      rr_d = rr_q;
      if (spawn) begin
         rr_d = (rr_q == LAST_COL) ? '0 : rr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign start_col   = rr_q;
   // The seed only matters when the random start column is built.
   assign unused_seed = ^LFSR_SEED;
`endif

   // ------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------
   // Column probe: with at most one armed bit per column, the last match
   // in row order is the only one; if several were set the lowest row wins.
   always_comb begin
      probe_hit = 1'b0;
      probe_row = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (armed_matrix[r][col_ptr_q]) begin
            probe_hit = 1'b1;
            probe_row = RW'(r);
         end
      end
   end

   assign spawn_x = formation_x + 16'(col_ptr_q) * SPACING_X + SPAWN_X_OFF;
   assign spawn_y = formation_y + 16'(probe_row) * SPACING_Y + SPAWN_Y_OFF;

   // Hit and bottom tests look at the position the bomb is about to take.
   assign fall_y      = bomb_y_q + FALL_STEP;
   assign fall_hit    = (bomb_x_q < player_x + PLAYER_W) && (player_x < bomb_x_q + BOMB_W) &&
                        (fall_y   < player_y + PLAYER_H) && (player_y < fall_y + BOMB_H);
   assign fall_bottom = (fall_y + BOMB_H) >= SCREEN_H;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cooldown_d    = cooldown_q;
      col_ptr_d     = col_ptr_q;
      probe_cnt_d   = probe_cnt_q;
      bomb_active_d = bomb_active_q;
      bomb_x_d      = bomb_x_q;
      bomb_y_d      = bomb_y_q;
      player_hit_d  = 1'b0;
      spawn         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (step_tick) begin
               // The tick that would take the cooldown to zero starts the search.
               if (cooldown_q <= 16'd1) begin
                  state_d     = ST_SELECT;
                  cooldown_d  = '0;
                  col_ptr_d   = start_col;
                  probe_cnt_d = '0;
               end else begin
                  cooldown_d = cooldown_q - 16'd1;
               end
            end
         end

         ST_SELECT: begin
            if (probe_hit) begin
               spawn         = 1'b1;
               bomb_x_d      = spawn_x;
               bomb_y_d      = spawn_y;
               bomb_active_d = 1'b1;
               state_d       = ST_FALL;
            end else if (probe_cnt_q == LAST_PROBE) begin
               // Every column probed empty: whole formation is unarmed.
               state_d    = ST_IDLE;
               cooldown_d = COOLDOWN_RELOAD;
            end else begin
               col_ptr_d   = (col_ptr_q == LAST_COL) ? '0 : col_ptr_q + 1'b1;
               probe_cnt_d = probe_cnt_q + 1'b1;
            end
         end

         ST_FALL: begin
            if (step_tick) begin
               bomb_y_d = fall_y;
               if (fall_hit) begin
                  player_hit_d  = 1'b1;
                  bomb_active_d = 1'b0;
                  state_d       = ST_IDLE;
                  cooldown_d    = COOLDOWN_RELOAD;
               end else if (fall_bottom) begin
                  bomb_active_d = 1'b0;
                  state_d       = ST_IDLE;
                  cooldown_d    = COOLDOWN_RELOAD;
               end
            end
         end

         default: begin
            state_d       = ST_IDLE;
            bomb_active_d = 1'b0;
            cooldown_d    = COOLDOWN_RELOAD;
         end
      endcase

      // Leaving the game overrides everything, including a hit on this step.
      if (!game_active) begin
         state_d       = ST_IDLE;
         bomb_active_d = 1'b0;
         cooldown_d    = COOLDOWN_RELOAD;
         player_hit_d  = 1'b0;
         spawn         = 1'b0;
      end
   end

   always_comb begin
      bomb_pixel_d = bomb_active_q &&
                     (scan_x >= bomb_x_q) && (scan_x < bomb_x_q + BOMB_W) &&
                     (scan_y >= bomb_y_q) && (scan_y < bomb_y_q + BOMB_H);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cooldown_q    <= COOLDOWN_RELOAD;
         col_ptr_q     <= '0;
         probe_cnt_q   <= '0;
         bomb_active_q <= 1'b0;
         bomb_x_q      <= '0;
         bomb_y_q      <= '0;
         bomb_pixel_q  <= 1'b0;
         player_hit_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cooldown_q    <= cooldown_d;
         col_ptr_q     <= col_ptr_d;
         probe_cnt_q   <= probe_cnt_d;
         bomb_active_q <= bomb_active_d;
         bomb_x_q      <= bomb_x_d;
         bomb_y_q      <= bomb_y_d;
         bomb_pixel_q  <= bomb_pixel_d;
         player_hit_q  <= player_hit_d;
      end
   end

   assign bomb_active = bomb_active_q;
   assign bomb_x      = bomb_x_q;
   assign bomb_y      = bomb_y_q;
   assign bomb_pixel  = bomb_pixel_q;
   assign player_hit  = player_hit_q;

endmodule

// File: tb/tb_alien_bomb_dropper.sv
// tb/tb_alien_bomb_dropper.sv - directed plus randomized bench for alien_bomb_dropper

module tb_alien_bomb_dropper;

   localparam int NR  = 2;
   localparam int NC  = 4;
   localparam int SPX = 64;
   localparam int SPY = 32;
   localparam int AW  = 32;
   localparam int AH  = 16;
   localparam int BW  = 2;
   localparam int BH  = 8;
   localparam int SPD = 4;
   localparam int SH  = 480;
   localparam int PW  = 32;
   localparam int PH  = 16;
   localparam int CD  = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  game_active;
   logic                  step_tick;
   logic [NR-1:0][NC-1:0] armed_matrix;
   logic [15:0]           formation_x, formation_y;
   logic [15:0]           player_x, player_y;
   logic [15:0]           scan_x, scan_y;
   logic                  bomb_active, bomb_pixel, player_hit;
   logic [15:0]           bomb_x, bomb_y;

   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: firing pointer and the bomb as the game rules see it.
   int   rr = 0;
   int   m_x = 0;
   int   m_y = 0;
   logic m_active = 1'b0;

   always #5 clk = ~clk;

   alien_bomb_dropper dut (
      .clk          (clk),
      .rst          (rst),
      .game_active  (game_active),
      .step_tick    (step_tick),
      .armed_matrix (armed_matrix),
      .formation_x  (formation_x),
      .formation_y  (formation_y),
      .player_x     (player_x),
      .player_y     (player_y),
      .scan_x       (scan_x),
      .scan_y       (scan_y),
      .bomb_active  (bomb_active),
      .bomb_x       (bomb_x),
      .bomb_y       (bomb_y),
      .bomb_pixel   (bomb_pixel),
      .player_hit   (player_hit)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_tick();
      step_tick = 1'b1;
      step();
      step_tick = 1'b0;
   endtask

   // Idle cycle with a random scan point around the model bomb.
   task automatic gap_cycle();
      logic exp_pix;
      scan_x = 16'(m_x - 3 + int'($urandom_range(0, 7)));
      scan_y = 16'(m_y - 3 + int'($urandom_range(0, 13)));
      exp_pix = m_active && (int'(scan_x) >= m_x) && (int'(scan_x) < m_x + BW) &&
                (int'(scan_y) >= m_y) && (int'(scan_y) < m_y + BH);
      step();
      check("bomb_pixel", bomb_pixel, exp_pix);
      check("no_stray_hit", player_hit, 0);
   endtask

   // Full cooldown, then the search. Expected column is the first armed one
   // walking forward from the firing pointer.
   task automatic cooldown_phase();
      int d, col, row, n;
      d = -1; col = 0; row = 0;
      for (int k = 0; k < NC; k++) begin
         int c;
         c = (rr + k) % NC;
         if (d < 0) begin
            for (int r = 0; r < NR; r++) begin
               if (armed_matrix[r][c]) begin
                  d = k; col = c; row = r;
               end
            end
         end
      end
      for (int t = 1; t <= CD; t++) begin
         repeat ($urandom_range(0, 2)) gap_cycle();
         do_tick();
         if (t < CD) check("no_early_spawn", bomb_active, 0);
      end
      if (d >= 0) begin
         n = 0;
         while (bomb_active !== 1'b1 && n < 3 * NC) begin
            step();
            n++;
         end
         check("spawn_latency", n, d + 1);
         m_x = int'(formation_x) + col * SPX + AW / 2 - BW / 2;
         m_y = int'(formation_y) + row * SPY + AH;
         check("spawn_x", bomb_x, m_x);
         check("spawn_y", bomb_y, m_y);
         m_active = 1'b1;
         rr = (rr + 1) % NC;
      end else begin
         for (int i = 0; i < NC + 2; i++) begin
            step();
            check("empty_no_spawn", bomb_active, 0);
         end
      end
   endtask

   // Drop the bomb for up to max_ticks steps, predicting hit / retire.
   task automatic fall(input int max_ticks);
      int   ny, px, py;
      logic hit, bot;
      for (int t = 0; t < max_ticks && m_active; t++) begin
         repeat ($urandom_range(0, 2)) gap_cycle();
         formation_x = 16'($urandom_range(40, 280));
         px  = int'(player_x);
         py  = int'(player_y);
         ny  = m_y + SPD;
         hit = (m_x < px + PW) && (px < m_x + BW) && (ny < py + PH) && (py < ny + BH);
         bot = (ny + BH) >= SH;
         do_tick();
         check("player_hit", player_hit, hit);
         check("bomb_x_frozen", bomb_x, m_x);
         if (hit || bot) begin
            m_active = 1'b0;
            check("bomb_active_end", bomb_active, 0);
            step();
            check("hit_pulse_width", player_hit, 0);
         end else begin
            m_y = ny;
            check("bomb_y", bomb_y, ny);
            check("bomb_active_fall", bomb_active, 1);
         end
      end
   endtask

   initial begin
      int v;
      rst = 1'b1; game_active = 1'b0; step_tick = 1'b0; armed_matrix = '0;
      formation_x = 16'd100; formation_y = 16'd50;
      player_x = 16'd1000; player_y = 16'd0; scan_x = '0; scan_y = '0;
      step();
      step();
      check("rst_bomb_active", bomb_active, 0);
      check("rst_bomb_x", bomb_x, 0);
      check("rst_bomb_y", bomb_y, 0);
      check("rst_bomb_pixel", bomb_pixel, 0);
      check("rst_player_hit", player_hit, 0);
      rst = 1'b0;
      game_active = 1'b1;

      // Whole bottom row armed: first bomb from column 0, then a silent retire.
      armed_matrix[1] = 4'hF;
      cooldown_phase();
      check("first_spawn_x", bomb_x, 115);
      check("first_spawn_y", bomb_y, 98);
      fall(200);

      // Dead formation: search gives up, cooldown restarts.
      armed_matrix = '0;
      cooldown_phase();

      // Random armed patterns, one alien per column at most, never empty.
      repeat (3) begin
         armed_matrix = '0;
         for (int c = 0; c < NC; c++) begin
            v = int'($urandom_range(0, 2));
            if (v == 1) armed_matrix[0][c] = 1'b1;
            if (v == 2) armed_matrix[1][c] = 1'b1;
         end
         if (armed_matrix == '0) armed_matrix[1][0] = 1'b1;
         formation_x = 16'($urandom_range(40, 280));
         cooldown_phase();
         player_x = 16'(m_x - 40 + int'($urandom_range(0, 50)));
         player_y = 16'($urandom_range(100, 470));
         fall(200);
      end

      // Only column 2 armed with the pointer back at 0; player under it.
      armed_matrix = '0;
      armed_matrix[1][2] = 1'b1;
      formation_x = 16'd100;
      player_x = 16'd235; player_y = 16'd300;
      cooldown_phase();
      check("col2_spawn_x", bomb_x, 243);
      fall(200);

      // Game stops mid-fall.
      armed_matrix = '0;
      armed_matrix[1] = 4'hF;
      formation_x = 16'd100;
      player_x = 16'd1000; player_y = 16'd0;
      cooldown_phase();
      fall(3);
      scan_x = 16'(m_x);
      scan_y = 16'(m_y + 3);
      step();
      check("pixel_inside", bomb_pixel, 1);
      game_active = 1'b0;
      step();
      check("drop_bomb_active", bomb_active, 0);
      check("drop_player_hit", player_hit, 0);
      step();
      check("drop_bomb_pixel", bomb_pixel, 0);
      m_active = 1'b0;
      game_active = 1'b1;

      // Hit and bottom on the same step: the hit must be reported.
      armed_matrix = '0;
      armed_matrix[0][1] = 1'b1;
      formation_x = 16'd100;
      player_x = 16'd170; player_y = 16'd479;
      cooldown_phase();
      fall(200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
